// File: rtl/q2_pkg.sv
// Shared definitions for the q2 serial ALU and its word-level sequencer.
package q2_pkg;

    localparam logic [1:0] Q2_OP_PASS = 2'b00;
    localparam logic [1:0] Q2_OP_NOR  = 2'b01;
    localparam logic [1:0] Q2_OP_ADD  = 2'b10;
    localparam logic [1:0] Q2_OP_SHR  = 2'b11;

    typedef enum logic [1:0] {
        Q2_IDLE = 2'd0,
        Q2_RUN  = 2'd1,
        Q2_DONE = 2'd2
    } q2_state_t;

endpackage

// File: rtl/q2_alu.sv
// 1-bit combinational ALU slice: pass / NOR / full-add / shift-right with a
// running flag that is a carry for add and a zero-detect for pass and NOR.
module q2_alu
    import q2_pkg::*;
(
    input  logic a0,
    input  logic x0,
    input  logic x1,
    input  logic f,
    input  logic o0,
    input  logic o1,
    output logic alu_out,
    output logic alu_cout
);

    always_comb begin
        alu_out  = 1'b0;
        alu_cout = 1'b0;
        case ({o1, o0})
            Q2_OP_PASS: begin
                alu_out  = x0;
                alu_cout = f & ~x0;
            end
            Q2_OP_NOR: begin
                alu_out  = ~(a0 | x0);
                alu_cout = f & (a0 | x0);
            end
            Q2_OP_ADD: begin
                alu_out  = a0 ^ x0 ^ f;
                alu_cout = (a0 & x0) | (a0 & f) | (x0 & f);
            end
            default: begin
                // Shift right: the next-higher X bit drops into this position.
                alu_out  = x1;
                alu_cout = f;
            end
        endcase
    end

endmodule

// File: rtl/q2_alu_seq.sv
// Word-level sequencer: streams a WIDTH-bit request LSB first through one
// q2_alu slice and assembles the serial result into a word plus final flag.
module q2_alu_seq
    import q2_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] x_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    q2_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_sh, x_sh, res_sh;
    logic             cin_q, flag;
    logic             run, last, accept;
    logic             alu_a0, alu_x0, alu_x1, alu_f, alu_o0, alu_o1;
    logic             alu_out, alu_cout;

    assign run    = (state == Q2_RUN);
    assign last   = run && (cnt == CNT_LAST);
    assign accept = start && (state != Q2_RUN);
    assign busy   = run;
    assign done   = (state == Q2_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= Q2_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            Q2_IDLE: if (start) state_nxt = Q2_RUN;
            Q2_RUN:  if (last)  state_nxt = Q2_DONE;
            Q2_DONE: state_nxt = start ? Q2_RUN : Q2_IDLE;
            default: state_nxt = Q2_IDLE;
        endcase
    end

    // Slice inputs are held at zero whenever no bit is being processed.
    always_comb begin
        alu_a0 = 1'b0;
        alu_x0 = 1'b0;
        alu_x1 = 1'b0;
        alu_f  = 1'b0;
        alu_o0 = 1'b0;
        alu_o1 = 1'b0;
        if (run) begin
            alu_a0 = a_sh[0];
            alu_x0 = x_sh[0];
            alu_x1 = x_sh[1];
            alu_f  = flag;
            alu_o0 = op_q[0];
            alu_o1 = op_q[1];
        end
    end

    q2_alu u_alu (
        .a0       (alu_a0),
        .x0       (alu_x0),
        .x1       (alu_x1),
        .f        (alu_f),
        .o0       (alu_o0),
        .o1       (alu_o1),
        .alu_out  (alu_out),
        .alu_cout (alu_cout)
    );

    // X refills its MSB with cin so the top bit of a shift sees cin as x1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            op_q   <= '0;
            a_sh   <= '0;
            x_sh   <= '0;
            res_sh <= '0;
            cin_q  <= 1'b0;
            flag   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            op_q   <= op;
            a_sh   <= a_in;
            x_sh   <= x_in;
            res_sh <= '0;
            cin_q  <= cin;
            flag   <= cin;
        end else if (run) begin
            cnt    <= cnt + 1'b1;
            a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
            x_sh   <= {cin_q, x_sh[WIDTH-1:1]};
            res_sh <= {alu_out, res_sh[WIDTH-1:1]};
            flag   <= alu_cout;
            if (last) begin
                result <= {alu_out, res_sh[WIDTH-1:1]};
                cout   <= alu_cout;
            end
        end
    end

endmodule

// File: tb/tb_q2_alu_seq.sv
// Scoreboard bench for q2_alu_seq: expected words come from a word-level model.
module tb_q2_alu_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] x_in = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] result;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [W:0] exp_q[$];

    q2_alu_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a_in   (a_in),
        .x_in   (x_in),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Word-level reference: returns {cout, result}.
    function automatic logic [W:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] x, input logic c);
        logic [W-1:0] r;
        case (o)
            2'b00: begin r = x; return {c & (r == '0), r}; end
            2'b01: begin r = ~(a | x); return {c & (r == '0), r}; end
            2'b10: return {1'b0, a} + {1'b0, x} + {{W{1'b0}}, c};
            default: return {c, c, x[W-1:1]};
        endcase
    endfunction

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                chk("result", 32'(result), 32'(e[W-1:0]));
                chk("cout", 32'(cout), 32'(e[W]));
            end
        end
    end

    task automatic drive(input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] x, input logic c, input bit push);
        op = o; a_in = a; x_in = x; cin = c; start = 1'b1;
        if (push) exp_q.push_back(model(o, a, x, c));
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] x, input logic c);
        drive(o, a, x, c, 1'b1);
        @(negedge clk);
        start = 1'b0;
        wait_done();
        @(negedge clk);
    endtask

    initial begin
        int d0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Latency of the first request: busy for W cycles then one done cycle.
        drive(2'b10, 16'h1234, 16'h0FFF, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            chk($sformatf("lat_busy%0d", i), 32'(busy), 32'd1);
            chk($sformatf("lat_nodone%0d", i), 32'(done), 32'd0);
            @(negedge clk);
        end
        chk("lat_done", 32'(done), 32'd1);
        chk("lat_idle", 32'(busy), 32'd0);
        chk("lat_result", 32'(result), 32'h2233);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("result_held", 32'(result), 32'h2233);

        run_op(2'b10, 16'hFFFF, 16'h0001, 1'b0);
        run_op(2'b10, 16'h7FFF, 16'h0000, 1'b1);
        run_op(2'b00, 16'h5A5A, 16'h0000, 1'b1);
        run_op(2'b00, 16'h5A5A, 16'h0080, 1'b1);
        run_op(2'b01, 16'h00FF, 16'h0F0F, 1'b1);
        run_op(2'b01, 16'hFFFF, 16'h0000, 1'b1);
        run_op(2'b11, 16'hFFFF, 16'h8001, 1'b1);
        run_op(2'b11, 16'h0000, 16'h0003, 1'b0);
        for (int i = 0; i < 6; i++)
            run_op(2'($urandom_range(3)), 16'($urandom), 16'($urandom), 1'($urandom_range(1)));

        // start during RUN at bit 5 must not disturb the latched request.
        drive(2'b10, 16'h1111, 16'h2222, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        drive(2'b01, 16'hAAAA, 16'h5555, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_done();
        @(negedge clk);
        chk("ignored_start_q", 32'(exp_q.size()), 32'd0);
        chk("ignored_start_idle", 32'(busy), 32'd0);

        // start held through DONE: next RUN begins right after the done cycle.
        drive(2'b10, 16'h0F0F, 16'h0101, 1'b1, 1'b1);
        @(negedge clk);
        drive(2'b00, 16'h0000, 16'hBEEF, 1'b0, 1'b1);
        wait_done();
        @(negedge clk);
        chk("held_start_busy", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done();
        @(negedge clk);
        chk("held_start_q", 32'(exp_q.size()), 32'd0);

        // Reset at bit 8 aborts with all outputs cleared and no done pulse.
        d0 = done_cnt;
        drive(2'b10, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_abort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 4) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt), 32'(d0));
        chk("abort_idle", 32'(busy), 32'd0);

        run_op(2'b10, 16'h8000, 16'h8000, 1'b1);
        chk("final_q", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x0 expected 0x1");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/q2_alu_seq.md
Name: q2_alu_seq

Overview:
Word-level sequencer for the q2 1-bit serial ALU. Accepts a WIDTH-bit operation request and streams operands through one q2_alu instance, LSB first, one bit per clock. It feeds the ALU carry/flag output back as the flag input on every bit. It captures the serial result and presents the full word plus the final flag.

Parameters:
WIDTH, 16, operand/result word width in bits (>= 2)

Ports:
clk      in   1      system clock
rst_n    in   1      reset: one clock; asynchronous, active-low
start    in   1      request; accepted only in IDLE or DONE
op       in   2      {o1,o0}: 00 pass x, 01 NOR(a,x), 10 add a+x+f, 11 shift right x (fill = cin)
a_in     in   WIDTH  operand A; ignored for op 00/11
x_in     in   WIDTH  operand X
cin      in   1      initial flag f: carry-in for add, zero-detect seed for 00/01, MSB fill and flag for 11
busy     out  1      high during RUN
done     out  1      one-cycle pulse when result is valid
result   out  WIDTH  result word; held until the next accepted start
cout     out  1      final flag after the last bit

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; busy=0, done=0, result=0, cout=0.
  - Internal shift registers, bit counter and flag are cleared.
- States:
  - IDLE: start=1 latches op, a_in, x_in and cin (as f). Goes to RUN, bit counter=0.
  - RUN: exactly WIDTH cycles. Counter 0..WIDTH-1, then goes to DONE.
  - DONE: done=1 for this single cycle, then goes to IDLE. start=1 in DONE is accepted exactly as in IDLE, going straight to RUN.
- start in RUN is ignored; the latched request is unaffected.
- Latency: start sampled at edge T gives busy=1 for cycles T+1..T+WIDTH, and done=1 in cycle T+WIDTH+1. Back-to-back requests give one result every WIDTH+1 cycles.
- Per RUN bit i, ALU inputs:
  - a0 = A[i], x0 = X[i].
  - x1 = X[i+1] for i<WIDTH-1; x1 = latched cin for i=WIDTH-1.
  - f = flag register.
  - o0, o1 from latched op.
  - Implementation: A and X shift right one bit per cycle. X's MSB is filled with latched cin, so x1 = X[1] of the shifted register.
- Each RUN edge:
  - flag <= alu_cout.
  - The result register shifts right with alu_out entering at the MSB. After WIDTH bits the result is in natural order.
- Resulting flag semantics:
  - 10: carry out.
  - 00/01: f stays 1 only while every result bit is 0, i.e. zero-detect AND cin.
  - 11: f is unchanged (= cin).
- cout <= flag at the RUN->DONE transition.
- result and cout update only at the RUN->DONE edge. Intermediate bits are held internally and never appear on result.
- Reset asserted mid-RUN aborts immediately to the reset state; no done is produced.
- ALU inputs are forced to 0 outside RUN.

Decomposition:
- Shared package q2_pkg holds:
  - Op-code constants: Q2_OP_PASS=2'b00, Q2_OP_NOR=2'b01, Q2_OP_ADD=2'b10, Q2_OP_SHR=2'b11.
  - State encoding for IDLE/RUN/DONE.
- One sub-module: the existing q2_alu, instantiated once as the combinational bit slice.
- Counter width: $clog2(WIDTH).

Test Plan:
- ADD, a=0x1234, x=0x0FFF, cin=0, start at T -> busy T+1..T+16; done only at T+17; result=0x2233, cout=0.
- ADD, a=0xFFFF, x=0x0001, cin=0 -> result=0x0000, cout=1. Then a=0x7FFF, x=0x0000, cin=1 -> result=0x8000, cout=0.
- PASS with cin=1:
  - x=0x0000 -> result=0x0000, cout=1.
  - x=0x0080 -> result=0x0080, cout=0.
- NOR, a=0x00FF, x=0x0F0F, cin=1 -> result=0xF000, cout=0. Then a=0xFFFF, x=0x0000, cin=1 -> result=0x0000, cout=1.
- SHR:
  - x=0x8001, cin=1 -> result=0xC000, cout=1.
  - x=0x0003, cin=0 -> result=0x0001, cout=0.
- Control:
  - start pulsed at bit 5 of a RUN -> ignored; result matches the first request.
  - start held high through DONE -> the next RUN begins the cycle after done.
  - rst_n low at bit 8 -> all outputs 0 immediately and no done pulse.
